// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter sequencer.
// Imported by the sequencer interface, target calculator and top level.
package pc_pkg;

    localparam int          XLEN_DEFAULT         = 32;
    localparam int          INC_BYTES_DEFAULT    = 4;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JAL,
        SEL_JALR,
        SEL_TRAP,
        SEL_MRET
    } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch handshake plus redirect sources between decode/execute and the PC sequencer.
// master = sequencer side, slave = surrounding pipeline / fetch.
interface pc_sequencer_if
    import pc_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            stall;
    logic            if_ready;
    logic            if_valid;
    logic            br_taken;
    logic            jal;
    logic            jalr;
    logic            halt;
    logic            trap;
    logic            mret;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] imm_val;
    logic [XLEN-1:0] pc_val;
    logic [XLEN-1:0] pc_plus4;
    logic            misalign;
    logic [XLEN-1:0] mepc;

    modport master (
        input  stall, if_ready, br_taken, jal, jalr, halt, trap, mret, rs1_val, imm_val,
        output if_valid, pc_val, pc_plus4, misalign, mepc
    );

    modport slave (
        output stall, if_ready, br_taken, jal, jalr, halt, trap, mret, rs1_val, imm_val,
        input  if_valid, pc_val, pc_plus4, misalign, mepc
    );
endinterface

// File: rtl/pc_sequencer_target_calc.sv
// Combinational next-PC candidates (sequential, PC-relative, JALR) and their alignment checks.
// INC_BYTES is assumed to be a power of two so alignment reduces to a low-bit mask.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int INC_BYTES = INC_BYTES_DEFAULT
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    output logic [XLEN-1:0] seq_pc_o,
    output logic [XLEN-1:0] rel_tgt_o,
    output logic [XLEN-1:0] jalr_tgt_o,
    output logic            rel_mis_o,
    output logic            jalr_mis_o
);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC_BYTES - 1);

    logic [XLEN-1:0] jalr_sum;

    assign seq_pc_o   = pc_i + XLEN'(INC_BYTES);
    assign rel_tgt_o  = pc_i + imm_i;
    assign jalr_sum   = rs1_i + imm_i;
    assign jalr_tgt_o = {jalr_sum[XLEN-1:1], 1'b0};

    assign rel_mis_o  = |(rel_tgt_o & ALIGN_MASK);
    assign jalr_mis_o = |(jalr_tgt_o & ALIGN_MASK);
endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register, boot/run/halt FSM and next-PC priority mux for the RV32I core.
// Define PC_TRAP_EN to enable trap/mret redirects, the mepc register and trap-on-misalign.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEFAULT),
    parameter int              INC_BYTES    = INC_BYTES_DEFAULT
) (
    input  logic           clk,
    input  logic           clr,
    pc_sequencer_if.master bus
);
`ifdef PC_TRAP_EN
    localparam bit TrapEn = 1'b1;
    logic trap_req, mret_req;
    assign trap_req = bus.trap;
    assign mret_req = bus.mret;
`else
    localparam bit TrapEn = 1'b0;
    logic trap_req, mret_req, unused_trap_inputs;
    assign trap_req           = 1'b0;
    assign mret_req           = 1'b0;
    assign unused_trap_inputs = bus.trap ^ bus.mret;
`endif

    pc_state_e       state_q, state_d;
    pc_sel_e         sel;
    logic [XLEN-1:0] pc_q, pc_d, mepc_q, mepc_d;
    logic            misalign_q, misalign_d, take_trap;
    logic [XLEN-1:0] seq_pc, rel_tgt, jalr_tgt;
    logic            rel_mis, jalr_mis;

    pc_target_calc #(.XLEN(XLEN), .INC_BYTES(INC_BYTES)) u_target_calc (
        .pc_i       (pc_q),
        .imm_i      (bus.imm_val),
        .rs1_i      (bus.rs1_val),
        .seq_pc_o   (seq_pc),
        .rel_tgt_o  (rel_tgt),
        .jalr_tgt_o (jalr_tgt),
        .rel_mis_o  (rel_mis),
        .jalr_mis_o (jalr_mis)
    );

    always_comb begin
        sel = SEL_SEQ;
        if      (trap_req)     sel = SEL_TRAP;
        else if (mret_req)     sel = SEL_MRET;
        else if (bus.jalr)     sel = SEL_JALR;
        else if (bus.jal)      sel = SEL_JAL;
        else if (bus.br_taken) sel = SEL_BR;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        mepc_d     = mepc_q;
        misalign_d = 1'b0;
        take_trap  = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                unique case (sel)
                    SEL_TRAP: take_trap = 1'b1;
                    SEL_MRET: pc_d = mepc_q;
                    SEL_JALR: begin
                        if (jalr_mis) begin
                            misalign_d = 1'b1;
                            take_trap  = TrapEn;
                        end else begin
                            pc_d = jalr_tgt;
                        end
                    end
                    SEL_JAL, SEL_BR: begin
                        if (rel_mis) begin
                            misalign_d = 1'b1;
                            take_trap  = TrapEn;
                        end else begin
                            pc_d = rel_tgt;
                        end
                    end
                    default: begin
                        // Halt alone freezes the PC rather than letting it step once more.
                        if (bus.if_ready && !bus.stall && !bus.halt) pc_d = seq_pc;
                    end
                endcase
                if (take_trap) begin
                    mepc_d = pc_q;
                    pc_d   = TRAP_VECTOR;
                end
                if (bus.halt) state_d = HALTED;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            mepc_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            state_q    <= state_d;
            pc_q       <= pc_d;
            mepc_q     <= mepc_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.if_valid = (state_q == RUN);
    assign bus.pc_val   = pc_q;
    assign bus.pc_plus4 = seq_pc;
    assign bus.misalign = misalign_q;
    assign bus.mepc     = TrapEn ? mepc_q : '0;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic vs a behavioural model.
// Follows PC_TRAP_EN the same way the design does.
module tb_pc_sequencer;
`ifdef PC_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam logic [31:0] TV = 32'h0000_0100;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    pc_sequencer_if #(.XLEN(32)) bus ();
    pc_sequencer dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    // Behavioural model: phase 0 = booting, 1 = running, 2 = halted.
    int          m_phase;
    logic [31:0] m_pc, m_mepc;
    bit          m_mis;

    function automatic void model_reset();
        m_phase = 0; m_pc = 32'h0; m_mepc = 32'h0; m_mis = 1'b0;
    endfunction

    function automatic void model_step();
        logic [31:0] tgt;
        bit          trap_go;
        m_mis = 1'b0;
        if (m_phase == 0) begin m_phase = 1; return; end
        if (m_phase != 1) return;
        trap_go = TRAP_EN && bus.trap;
        if (trap_go) begin
        end else if (TRAP_EN && bus.mret) begin
            m_pc = m_mepc;
        end else if (bus.jalr || bus.jal || bus.br_taken) begin
            tgt = bus.jalr ? ((bus.rs1_val + bus.imm_val) & ~32'h1) : m_pc + bus.imm_val;
            if (tgt % 4 != 0) begin m_mis = 1'b1; trap_go = TRAP_EN; end
            else m_pc = tgt;
        end else if (bus.if_ready && !bus.stall && !bus.halt) begin
            m_pc = m_pc + 4;
        end
        if (trap_go) begin m_mepc = m_pc; m_pc = TV; end
        if (bus.halt) m_phase = 2;
    endfunction

    task automatic idle_inputs();
        bus.stall = 0; bus.if_ready = 0; bus.br_taken = 0; bus.jal = 0; bus.jalr = 0;
        bus.halt = 0; bus.trap = 0; bus.mret = 0; bus.rs1_val = 0; bus.imm_val = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_pc(input logic [31:0] addr);
        idle_inputs();
        bus.jalr = 1; bus.rs1_val = addr;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.if_ready = 1;
        clr = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors += 4;
        if (bus.pc_val !== 32'h0)  begin miscompares++; $display("FAIL reset_pc got=%h exp=%h", bus.pc_val, 32'h0); end
        if (bus.if_valid !== 1'b0) begin miscompares++; $display("FAIL reset_if_valid got=%b exp=0", bus.if_valid); end
        if (bus.misalign !== 1'b0) begin miscompares++; $display("FAIL reset_misalign got=%b exp=0", bus.misalign); end
        if (bus.mepc !== 32'h0)    begin miscompares++; $display("FAIL reset_mepc got=%h exp=0", bus.mepc); end
        clr = 1;
        #1;
        vectors++;
        if (bus.if_valid !== 1'b0) begin miscompares++; $display("FAIL boot_if_valid got=%b exp=0", bus.if_valid); end
        tick();
        vectors += 2;
        if (bus.if_valid !== 1'b1) begin miscompares++; $display("FAIL run_if_valid got=%b exp=1", bus.if_valid); end
        if (bus.pc_val !== 32'h0)  begin miscompares++; $display("FAIL boot_pc got=%h exp=0", bus.pc_val); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        bus.if_ready = 1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            exp_pc = 32'(4 * i);
            vectors++;
            if (bus.pc_val !== exp_pc) begin miscompares++; $display("FAIL seq_step got=%h exp=%h", bus.pc_val, exp_pc); end
        end
        vectors++;
        if (bus.pc_plus4 !== 32'hC) begin miscompares++; $display("FAIL pc_plus4 got=%h exp=%h", bus.pc_plus4, 32'hC); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            bus.if_ready = (i != 0);
            bus.stall    = (i != 0);
            tick();
            vectors++;
            if (bus.pc_val !== 32'h8) begin miscompares++; $display("FAIL stall_hold got=%h exp=%h", bus.pc_val, 32'h8); end
        end
        bus.stall = 0; bus.if_ready = 1;
        tick();
        vectors++;
        if (bus.pc_val !== 32'hC) begin miscompares++; $display("FAIL stall_resume got=%h exp=%h", bus.pc_val, 32'hC); end
    endtask

    task automatic test_branch_priority();
        goto_pc(32'h20);
        bus.br_taken = 1; bus.imm_val = 32'hFFFF_FFF8;
        tick();
        vectors++;
        if (bus.pc_val !== 32'h18) begin miscompares++; $display("FAIL branch_back got=%h exp=%h", bus.pc_val, 32'h18); end
        bus.imm_val = 0; bus.jalr = 1; bus.rs1_val = 32'h101;
        tick();
        vectors++;
        if (bus.pc_val !== 32'h100) begin miscompares++; $display("FAIL jalr_wins got=%h exp=%h", bus.pc_val, 32'h100); end
        idle_inputs();
    endtask

    task automatic test_misalign();
        logic [31:0] exp_pc;
        goto_pc(32'h40);
        bus.jal = 1; bus.imm_val = 32'd6;
        tick();
        exp_pc = TRAP_EN ? TV : 32'h40;
        vectors += 2;
        if (bus.misalign !== 1'b1) begin miscompares++; $display("FAIL misalign_pulse got=%b exp=1", bus.misalign); end
        if (bus.pc_val !== exp_pc) begin miscompares++; $display("FAIL misalign_pc got=%h exp=%h", bus.pc_val, exp_pc); end
        if (TRAP_EN) begin
            vectors++;
            if (bus.mepc !== 32'h40) begin miscompares++; $display("FAIL misalign_mepc got=%h exp=%h", bus.mepc, 32'h40); end
        end
        idle_inputs();
        tick();
        vectors++;
        if (bus.misalign !== 1'b0) begin miscompares++; $display("FAIL misalign_clear got=%b exp=0", bus.misalign); end
    endtask

    task automatic test_trap();
        logic [31:0] exp_pc;
        goto_pc(32'h80);
        bus.trap = 1; bus.if_ready = 1;
        tick();
        exp_pc = TRAP_EN ? TV : 32'h84;
        vectors += 2;
        if (bus.pc_val !== exp_pc) begin miscompares++; $display("FAIL trap_pc got=%h exp=%h", bus.pc_val, exp_pc); end
        if (bus.mepc !== (TRAP_EN ? 32'h80 : 32'h0)) begin
            miscompares++; $display("FAIL trap_mepc got=%h exp=%h", bus.mepc, TRAP_EN ? 32'h80 : 32'h0);
        end
        bus.trap = 0; bus.mret = 1;
        tick();
        exp_pc = TRAP_EN ? 32'h80 : 32'h88;
        vectors++;
        if (bus.pc_val !== exp_pc) begin miscompares++; $display("FAIL mret_pc got=%h exp=%h", bus.pc_val, exp_pc); end
        idle_inputs();
    endtask

    task automatic test_halt_and_wrap();
        goto_pc(32'h10);
        bus.halt = 1; bus.if_ready = 1;
        tick();
        vectors += 2;
        if (bus.if_valid !== 1'b0) begin miscompares++; $display("FAIL halt_if_valid got=%b exp=0", bus.if_valid); end
        if (bus.pc_val !== 32'h10) begin miscompares++; $display("FAIL halt_pc got=%h exp=%h", bus.pc_val, 32'h10); end
        bus.halt = 0; bus.jal = 1; bus.imm_val = 32'd8;
        tick();
        vectors++;
        if (bus.pc_val !== 32'h10) begin miscompares++; $display("FAIL halt_ignores_jal got=%h exp=%h", bus.pc_val, 32'h10); end
        idle_inputs();
        goto_pc(32'h24);
        clr = 0;
        #2;
        model_reset();
        vectors += 2;
        if (bus.pc_val !== 32'h0)  begin miscompares++; $display("FAIL clr_async_pc got=%h exp=0", bus.pc_val); end
        if (bus.if_valid !== 1'b0) begin miscompares++; $display("FAIL clr_async_valid got=%b exp=0", bus.if_valid); end
        clr = 1;
        tick();
        vectors++;
        if (bus.if_valid !== 1'b1) begin miscompares++; $display("FAIL reboot_valid got=%b exp=1", bus.if_valid); end
        goto_pc(32'hFFFF_FFFC);
        vectors++;
        if (bus.pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL wrap_plus4 got=%h exp=0", bus.pc_plus4); end
        bus.if_ready = 1;
        tick();
        vectors++;
        if (bus.pc_val !== 32'h0) begin miscompares++; $display("FAIL wrap_pc got=%h exp=0", bus.pc_val); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [31:0] exp_mepc;
        for (int n = 0; n < 400; n++) begin
            if (m_phase == 2 && $urandom_range(0, 3) == 0) begin
                clr = 0; #1; model_reset(); clr = 1;
            end
            bus.stall    = ($urandom_range(0, 3) == 0);
            bus.if_ready = ($urandom_range(0, 3) != 0);
            bus.br_taken = ($urandom_range(0, 7) == 0);
            bus.jal      = ($urandom_range(0, 9) == 0);
            bus.jalr     = ($urandom_range(0, 9) == 0);
            bus.trap     = ($urandom_range(0, 15) == 0);
            bus.mret     = ($urandom_range(0, 15) == 0);
            bus.halt     = ($urandom_range(0, 49) == 0);
            bus.rs1_val  = $urandom;
            bus.imm_val  = 32'($urandom_range(0, 128)) - 32'd64;
            tick();
            exp_mepc = TRAP_EN ? m_mepc : 32'h0;
            vectors += 5;
            if (bus.pc_val !== m_pc) begin miscompares++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", n, bus.pc_val, m_pc); end
            if (bus.pc_plus4 !== m_pc + 32'd4) begin miscompares++; $display("FAIL rand_plus4 cyc=%0d got=%h exp=%h", n, bus.pc_plus4, m_pc + 32'd4); end
            if (bus.if_valid !== (m_phase == 1)) begin miscompares++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", n, bus.if_valid, m_phase == 1); end
            if (bus.misalign !== m_mis) begin miscompares++; $display("FAIL rand_misalign cyc=%0d got=%b exp=%b", n, bus.misalign, m_mis); end
            if (bus.mepc !== exp_mepc) begin miscompares++; $display("FAIL rand_mepc cyc=%0d got=%h exp=%h", n, bus.mepc, exp_mepc); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_priority();
        test_misalign();
        test_trap();
        test_halt_and_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
